// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory master: access sizes and FSM state encoding.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/dmem_lane_mux.sv
// Little-endian byte-lane steering: load extraction/extension, store lane merge and
// alignment check for a 32-bit word memory.
module dmem_lane_mux
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word_i[{lane_i, 3'b000} +: 8];
    half_sel   = word_i[{lane_i[1], 4'b0000} +: 16];
    ld_data_o  = word_i;
    st_word_o  = word_i;
    misalign_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        st_word_o[{lane_i, 3'b000} +: 8] = st_data_i[7:0];
      end
      SIZE_HALF: begin
        ld_data_o  = {{16{signed_i & half_sel[15]}}, half_sel};
        st_word_o[{lane_i[1], 4'b0000} +: 16] = st_data_i[15:0];
        misalign_o = lane_i[0];
      end
      SIZE_WORD: begin
        ld_data_o  = word_i;
        st_word_o  = st_data_i;
        misalign_o = |lane_i;
      end
      // The reserved size code is reported through the same error path.
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_master.sv
// Load/store initiator for a word-addressed async-read, negedge-write data memory.
// One request in flight; sub-word stores are done as read-modify-write.
module dmem_master
  import dmem_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int RdWait   = 2
) (
  input  logic                CLK,
  input  logic                Reset_L,
  input  logic                Req_Valid,
  input  logic                Req_Wr,
  input  logic [1:0]          Req_Size,
  input  logic                Req_Signed,
  input  logic [WordSize-1:0] Req_Addr,
  input  logic [WordSize-1:0] Req_Data,
  output logic                Busy,
  output logic                Rsp_Valid,
  output logic                Rsp_Err,
  output logic [WordSize-1:0] Rsp_Data,
  output logic [WordSize-1:0] Mem_Addr,
  output logic                Mem_rd,
  output logic                Mem_wr,
  output logic [WordSize-1:0] Mem_DIN,
  input  logic [WordSize-1:0] Mem_DOUT
);

  localparam int CntW = (RdWait > 1) ? $clog2(RdWait) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(RdWait - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                wr_q, sgn_q;
  logic [1:0]          size_q, lane_q;
  logic [WordSize-1:0] data_q, addr_q, din_q, ld_q;

  logic                idle;
  logic [1:0]          mux_lane, mux_size;
  logic [WordSize-1:0] ld_data, st_word;
  logic                bad_req, rd_last;

  assign idle    = (state_q == IDLE);
  assign rd_last = (state_q == RD) && (cnt_q == '0);

  // In IDLE the mux checks the incoming request; afterwards it works on the latched one.
  assign mux_lane = idle ? Req_Addr[1:0] : lane_q;
  assign mux_size = idle ? Req_Size      : size_q;

  dmem_lane_mux u_lane_mux (
    .word_i     (Mem_DOUT),
    .lane_i     (mux_lane),
    .size_i     (mux_size),
    .signed_i   (sgn_q),
    .st_data_i  (data_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word),
    .misalign_o (bad_req)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    Busy      = !idle;
    Rsp_Valid = (state_q == DONE) || (state_q == ERR);
    Rsp_Err   = (state_q == ERR);
    Rsp_Data  = ((state_q == DONE) && !wr_q) ? ld_q : '0;
    Mem_rd    = (state_q == RD);
    Mem_wr    = (state_q == WR);
    case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          if (bad_req) begin
            state_d = ERR;
          end else if (Req_Wr && (Req_Size == SIZE_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
            cnt_d   = CntLoad;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) state_d = wr_q ? WR : DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      wr_q   <= 1'b0;
      sgn_q  <= 1'b0;
      size_q <= '0;
      lane_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      din_q  <= '0;
      ld_q   <= '0;
    end else begin
      if (idle && Req_Valid) begin
        wr_q   <= Req_Wr;
        sgn_q  <= Req_Signed;
        size_q <= Req_Size;
        lane_q <= Req_Addr[1:0];
        data_q <= Req_Data;
        addr_q <= {Req_Addr[WordSize-1:2], 2'b00};
        din_q  <= Req_Data;
      end
      // Last read cycle: capture the extended load value and the merged RMW word.
      if (rd_last) begin
        ld_q  <= ld_data;
        din_q <= st_word;
      end
    end
  end

  assign Mem_Addr = addr_q;
  assign Mem_DIN  = din_q;

endmodule
